// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 8-channel round-robin mux arbiter.
package rr_arb_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod 8.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [N_CH-1:0]  rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        // Rotate right so the channel at ptr lands in bit 0.
        rot = N_CH'({req, req} >> ptr);
        off = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/rr_arb_8ch.sv
// Eight-channel round-robin arbiter with hold timer and one-cycle turnaround gap.
module rr_arb_8ch
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CW       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    output logic [N_CH-1:0]   gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              gnt_valid,
    output logic              timeout
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_CH-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              gv_q, gv_d;
    logic              tout_q, tout_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        gv_d    = gv_q;
        tout_d  = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = N_CH'(1) << pick_idx;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CW'(1);
                if (!req[sel_q] || cnt_q == CW'(HOLD_MAX - 1)) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                    // A simultaneous release wins over the timer: no pulse then.
                    tout_d  = req[sel_q];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                gv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            gv_q    <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            gv_q    <= gv_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gv_q;
    assign timeout   = tout_q;

endmodule

// File: tb/tb_rr_arb_8ch.sv
// Bench for rr_arb_8ch: hand-written vector tables plus a cycle model feeding a scoreboard.
module tb_rr_arb_8ch;

    localparam int unsigned HM  = 4;
    localparam int unsigned HM2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, req2;
    logic [7:0] gnt, gnt2;
    logic [2:0] sel, sel2;
    logic       gnt_valid, gnt_valid2;
    logic       timeout, timeout2;

    always #5 clk = ~clk;

    rr_arb_8ch #(.HOLD_MAX(HM), .CW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
        .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_arb_8ch #(.HOLD_MAX(HM2), .CW(4)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .gnt(gnt2), .sel(sel2),
        .gnt_valid(gnt_valid2), .timeout(timeout2)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       gv;
        logic       tout;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       tout;
    } vec_t;

    exp_t sbq[$];
    vec_t tab[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state (HOLD_MAX = HM)
    int         m_st;
    logic [2:0] m_ptr;
    int         m_cnt;
    logic [7:0] m_gnt;
    logic [2:0] m_sel;
    logic       m_tout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic [2:0] p);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (int'(p) + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ptr = 3'd0; m_cnt = 0; m_gnt = 8'h00; m_sel = 3'd0; m_tout = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int w;
        exp_t e;
        w = pick(r, m_ptr);
        m_tout = 1'b0;
        if (m_st == 1) begin
            if (r[m_sel] == 1'b0) begin
                m_st = 2; m_gnt = 8'h00; m_ptr = m_sel + 3'd1;
            end else if (m_cnt == int'(HM) - 1) begin
                m_st = 2; m_gnt = 8'h00; m_ptr = m_sel + 3'd1; m_tout = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (w >= 0) begin
            m_st = 1; m_sel = 3'(w); m_gnt = 8'h01 << w; m_cnt = 0;
        end else begin
            m_st = 0;
        end
        e.gnt  = m_gnt;
        e.sel  = m_sel;
        e.gv   = (m_gnt != 8'h00);
        e.tout = m_tout;
        sbq.push_back(e);
    endtask

    // One clock: drive req, predict, let the edge happen, compare on the falling edge.
    task automatic cycle(input logic [7:0] r);
        exp_t e;
        req = r;
        model_step(r);
        @(posedge clk);
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 expected=1 entry at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("sb_gnt",  32'(gnt),       32'(e.gnt));
            chk("sb_sel",  32'(sel),       32'(e.sel));
            chk("sb_gv",   32'(gnt_valid), 32'(e.gv));
            chk("sb_tout", 32'(timeout),   32'(e.tout));
        end
    endtask

    task automatic run_tab(input string tag);
        foreach (tab[i]) begin
            cycle(tab[i].req);
            chk({tag, "_gnt"},  32'(gnt),     32'(tab[i].gnt));
            chk({tag, "_sel"},  32'(sel),     32'(tab[i].sel));
            chk({tag, "_tout"}, 32'(timeout), 32'(tab[i].tout));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic prev_gv;
        int   order_n;
        int   tcount;

        rst = 1'b1; req = 8'h00; req2 = 8'h00;
        model_reset();
        @(negedge clk);
        chk("rst_gnt",  32'(gnt),       32'h00);
        chk("rst_sel",  32'(sel),       32'd0);
        chk("rst_gv",   32'(gnt_valid), 32'd0);
        chk("rst_tout", 32'(timeout),   32'd0);
        chk("rst_gnt2", 32'(gnt2),      32'h00);
        rst = 1'b0;

        // Single request on ch2 for three cycles, then GAP and IDLE.
        tab = '{'{8'h04, 8'h04, 3'd2, 1'b0}, '{8'h04, 8'h04, 3'd2, 1'b0},
                '{8'h04, 8'h04, 3'd2, 1'b0}, '{8'h00, 8'h00, 3'd2, 1'b0},
                '{8'h00, 8'h00, 3'd2, 1'b0}, '{8'h00, 8'h00, 3'd2, 1'b0}};
        run_tab("single");

        // ch7 release wraps ptr to 0, so ch0 beats ch7; then ch7 follows.
        tab = '{'{8'h80, 8'h80, 3'd7, 1'b0}, '{8'h80, 8'h80, 3'd7, 1'b0},
                '{8'h00, 8'h00, 3'd7, 1'b0}, '{8'h81, 8'h01, 3'd0, 1'b0},
                '{8'h81, 8'h01, 3'd0, 1'b0}, '{8'h80, 8'h00, 3'd0, 1'b0},
                '{8'h80, 8'h80, 3'd7, 1'b0}, '{8'h00, 8'h00, 3'd7, 1'b0},
                '{8'h00, 8'h00, 3'd7, 1'b0}};
        run_tab("wrap");

        // All channels requesting: 4-cycle grants, 1-cycle gaps with timeout pulses.
        prev_gv = 1'b0; order_n = 0; tcount = 0;
        for (int c = 0; c < 42; c++) begin
            cycle(8'hFF);
            if (timeout) tcount++;
            if (gnt_valid && !prev_gv) begin
                chk("rot_order", 32'(sel), 32'(order_n % 8));
                order_n++;
            end
            prev_gv = gnt_valid;
        end
        chk("rot_timeouts", 32'(tcount),  32'd8);
        chk("rot_grants",   32'(order_n), 32'd9);
        cycle(8'h00);
        cycle(8'h00);

        // ch1 drops exactly on its 4th grant cycle: release wins, no pulse, ptr=2.
        tab = '{'{8'h02, 8'h02, 3'd1, 1'b0}, '{8'h02, 8'h02, 3'd1, 1'b0},
                '{8'h02, 8'h02, 3'd1, 1'b0}, '{8'h02, 8'h02, 3'd1, 1'b0},
                '{8'h00, 8'h00, 3'd1, 1'b0}, '{8'h06, 8'h04, 3'd2, 1'b0},
                '{8'h00, 8'h00, 3'd2, 1'b0}, '{8'h00, 8'h00, 3'd2, 1'b0}};
        run_tab("reltout");

        // Reset in the middle of a ch3 grant.
        cycle(8'h08);
        chk("pre_rst_gnt", 32'(gnt), 32'h08);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt),       32'h00);
        chk("mid_rst_sel", 32'(sel),       32'd0);
        chk("mid_rst_gv",  32'(gnt_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(8'hFF);
        chk("post_rst_sel", 32'(sel), 32'd0);
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        cycle(8'h00);
        cycle(8'h00);

        // Sole requester ch5 on the HOLD_MAX=2 instance: 2 on, 1 gap with timeout.
        tab = '{'{8'h20, 8'h20, 3'd5, 1'b0}, '{8'h20, 8'h20, 3'd5, 1'b0},
                '{8'h20, 8'h00, 3'd5, 1'b1}, '{8'h20, 8'h20, 3'd5, 1'b0},
                '{8'h20, 8'h20, 3'd5, 1'b0}, '{8'h20, 8'h00, 3'd5, 1'b1},
                '{8'h20, 8'h20, 3'd5, 1'b0}, '{8'h20, 8'h20, 3'd5, 1'b0},
                '{8'h20, 8'h00, 3'd5, 1'b1}, '{8'h00, 8'h00, 3'd5, 1'b0}};
        foreach (tab[i]) begin
            req2 = tab[i].req;
            cycle(8'h00);
            chk("sole_gnt",  32'(gnt2),       32'(tab[i].gnt));
            chk("sole_sel",  32'(sel2),       32'(tab[i].sel));
            chk("sole_gv",   32'(gnt_valid2), 32'(tab[i].gnt != 8'h00));
            chk("sole_tout", 32'(timeout2),   32'(tab[i].tout));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
